aud_pwm_dac: RTL and testbench
==============================

AUD_PWM_DAC -- requirements
Module: aud_pwm_dac

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 10, meaning sample/duty width; PWM period is 2^SAMPLE_W clk cycles.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk  in  1  meaning the single clock (125 MHz in z1top); all logic is in this domain.
REQ-004 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  meaning playback enable from CPU MMIO.
REQ-006 SHALL have port sample_in  in  SAMPLE_W  meaning unsigned duty sample from the upstream wave generator.
REQ-007 SHALL have port sample_in_valid  in  1  meaning the producer holds a sample.
REQ-008 SHALL have port sample_in_ready  out  1  meaning the block accepts a sample this cycle.
REQ-009 SHALL have port aud_pwm  out  1  meaning the PWM audio output.
REQ-010 SHALL have port aud_sd  out  1  meaning amplifier shutdown-not; 1 means amplifier on.
REQ-011 SHALL have port underrun  out  1  meaning a one-cycle pulse on a starved period boundary.
REQ-012 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  meaning current buffer occupancy.

Function
REQ-013 SHALL accept a sample on a cycle where sample_in_valid and sample_in_ready are both 1; sample_in_ready SHALL equal (level != FIFO_DEPTH) and SHALL NOT depend combinationally on any pop.
REQ-014 SHALL keep the level unchanged on a same-cycle push and pop; when the FIFO is full, a pop frees the slot for the next cycle only.
REQ-015 SHALL run FSM states OFF, PRIME, PLAY; reset enters OFF.
REQ-016 SHALL, in OFF: drive aud_pwm=0 and aud_sd=0, hold the counter at 0, flush the FIFO, and hold sample_in_ready=0; on enable=1, go to PRIME.
REQ-017 SHALL, in PRIME: set sample_in_ready per REQ-013; on the first cycle with level>0, pop the sample into duty, set the counter to 0 and go to PLAY.
REQ-018 SHALL, in PLAY: increment the counter each cycle, wrapping from 2^SAMPLE_W-1 to 0; aud_pwm SHALL be registered as (counter < duty); aud_sd SHALL be 1.
REQ-019 SHALL, at counter = 2^SAMPLE_W-1: pop the head into duty if level>0, with the new duty applying from counter 0; otherwise keep duty and pulse underrun for one cycle.
REQ-020 SHALL produce, for duty=0, aud_pwm constantly 0; for duty=2^SAMPLE_W-1, aud_pwm high for 2^SAMPLE_W-1 of every 2^SAMPLE_W cycles.
REQ-021 SHALL, when enable=0 in PRIME or PLAY, enter OFF on the next edge, abandoning the current period; OFF outputs SHALL apply from that edge.
REQ-022 SHALL have a latency of 2 cycles from an accepting push into an empty FIFO in PRIME to aud_pwm reflecting that sample.

Reset
REQ-023 SHALL, on asserting rst_n=0, immediately force state=OFF, aud_pwm=0, aud_sd=0, underrun=0, sample_in_ready=0, fifo_level=0, counter=0 and duty=0, including mid-period; release SHALL be synchronous to clk.

Configuration
REQ-024 SHALL, with AUD_DAC_UNDERRUN_CNT_EN defined, add output port underrun_count (16 bits): it increments on each underrun pulse, saturates at 16'hFFFF, and clears only on reset.
REQ-025 SHALL, without AUD_DAC_UNDERRUN_CNT_EN, omit the underrun_count port and counter; all other behaviour SHALL be identical.

Structure
REQ-026 SHALL take the FSM state enum and the default parameter values from the shared package aud_dac_pkg.
REQ-027 SHALL instantiate the buffer as sub-module aud_sample_fifo, a synchronous FIFO with push/pop/full/empty/level; the FSM and PWM counter SHALL stay in aud_pwm_dac.

Verification
REQ-028 SHALL check reset and OFF: hold rst_n=0 for 10 cycles with enable=1 -> aud_pwm=0, aud_sd=0, sample_in_ready=0 throughout.
REQ-029 SHALL check basic PWM: enable=1, push 10'd256 -> aud_pwm high for exactly 256 of each 1024 cycles, aud_sd=1, and the first high edge 2 cycles after the push.
REQ-030 SHALL check extremes: push 0 then 1023 -> one period all low, then 1023 high followed by 1 low.
REQ-031 SHALL check backpressure: hold valid=1 with no pops -> ready drops after 4 accepts and fifo_level=4; ready returns to 1 the cycle after the boundary pop.
REQ-032 SHALL check underrun: one sample of 512, then none -> underrun pulses at each boundary, duty stays 512, and underrun_count=3 after 3 periods (with the macro defined).
REQ-033 SHALL check mid-period drop: set enable=0 at counter=300 -> aud_pwm=0 and aud_sd=0 the next cycle and fifo_level=0; re-enabling passes through PRIME.

Source files
------------

// File: rtl/aud_dac_pkg.sv
// Shared types and default parameters for the PWM audio DAC slice.
// The playback FSM state encoding lives here so the top and the bench agree on it.
package aud_dac_pkg;

   localparam int SAMPLE_W_DEF   = 10;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_PRIME = 2'd1,
      ST_PLAY  = 2'd2
   } dac_state_t;

endpackage

// File: rtl/aud_sample_fifo.sv
// Synchronous sample FIFO with flush; push is ignored when full, pop when empty.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module aud_sample_fifo
   import aud_dac_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; level/pointers gate every read, so stale data is never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/aud_pwm_dac.sv
// PWM audio DAC: buffered samples set the duty of a 2^SAMPLE_W-cycle PWM period.
// Optional feature: define AUD_DAC_UNDERRUN_CNT_EN to add a saturating underrun_count output.
module aud_pwm_dac
   import aud_dac_pkg::*;
#(
   parameter int SAMPLE_W   = SAMPLE_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [SAMPLE_W-1:0]           sample_in,
   input  logic                          sample_in_valid,
   output logic                          sample_in_ready,
   output logic                          aud_pwm,
   output logic                          aud_sd,
   output logic                          underrun,
`ifdef AUD_DAC_UNDERRUN_CNT_EN
   output logic [15:0]                   underrun_count,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;

   dac_state_t          state, state_next;
   logic [SAMPLE_W-1:0] counter, counter_next;
   logic [SAMPLE_W-1:0] duty, duty_next;
   logic                pwm_next;
   logic                sd_next;
   logic                underrun_next;
   logic                pop;
   logic                flush;
   logic                fifo_full;
   logic                fifo_empty;
   logic [SAMPLE_W-1:0] fifo_dout;

   // Ready comes only from registered state, never from this cycle's pop.
   assign sample_in_ready = (state != ST_OFF) && !fifo_full;
   assign flush           = (state_next == ST_OFF);

   aud_sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (sample_in_valid && sample_in_ready),
      .pop   (pop),
      .din   (sample_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next    = state;
      counter_next  = counter;
      duty_next     = duty;
      pwm_next      = 1'b0;
      sd_next       = 1'b0;
      underrun_next = 1'b0;
      pop           = 1'b0;
      unique case (state)
         ST_OFF: begin
            counter_next = '0;
            if (enable) state_next = ST_PRIME;
         end
         ST_PRIME: begin
            if (!enable) begin
               state_next   = ST_OFF;
               counter_next = '0;
            end else if (!fifo_empty) begin
               pop          = 1'b1;
               duty_next    = fifo_dout;
               counter_next = '0;
               sd_next      = 1'b1;
               state_next   = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (!enable) begin
               state_next   = ST_OFF;
               counter_next = '0;
            end else begin
               sd_next      = 1'b1;
               pwm_next     = (counter < duty);
               counter_next = counter + SAMPLE_W'(1);
               // Period boundary: reload duty for the next period or flag starvation.
               if (counter == CNT_MAX) begin
                  if (!fifo_empty) begin
                     pop       = 1'b1;
                     duty_next = fifo_dout;
                  end else begin
                     underrun_next = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_next   = ST_OFF;
            counter_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_OFF;
         counter  <= '0;
         duty     <= '0;
         aud_pwm  <= 1'b0;
         aud_sd   <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state    <= state_next;
         counter  <= counter_next;
         duty     <= duty_next;
         aud_pwm  <= pwm_next;
         aud_sd   <= sd_next;
         underrun <= underrun_next;
      end
   end

`ifdef AUD_DAC_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_count <= '0;
      end else if (underrun_next && (underrun_count != 16'hFFFF)) begin
         underrun_count <= underrun_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aud_pwm_dac.sv
// Directed bench for aud_pwm_dac (SAMPLE_W=10, FIFO_DEPTH=4).
// Edge Ek below means the k-th rising edge after the accepting push edge E0.
module tb_aud_pwm_dac;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [9:0]  sample_in = '0;
   logic        sample_in_valid = 1'b0;
   logic        sample_in_ready;
   logic        aud_pwm;
   logic        aud_sd;
   logic        underrun;
   logic [2:0]  fifo_level;
`ifdef AUD_DAC_UNDERRUN_CNT_EN
   logic [15:0] underrun_count;
`endif

   int total = 0;
   int bad   = 0;

   always #4 clk = ~clk;

   aud_pwm_dac #(
      .SAMPLE_W   (10),
      .FIFO_DEPTH (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .sample_in       (sample_in),
      .sample_in_valid (sample_in_valid),
      .sample_in_ready (sample_in_ready),
      .aud_pwm         (aud_pwm),
      .aud_sd          (aud_sd),
      .underrun        (underrun),
`ifdef AUD_DAC_UNDERRUN_CNT_EN
      .underrun_count  (underrun_count),
`endif
      .fifo_level      (fifo_level)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      sample_in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Offers one sample and returns 1 time unit after the edge that accepted it.
   task automatic push(input logic [9:0] v);
      bit ok = 1'b0;
      sample_in = v;
      sample_in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = sample_in_ready;
         tick();
      end
      sample_in_valid = 1'b0;
      if (!ok) begin
         total++; bad++;
         $display("FAIL push_timeout: sample %0d not accepted within 50 cycles", v);
      end
   endtask

   task automatic test_reset();
      int errs = 0;
      rst_n = 1'b0;
      enable = 1'b1;
      sample_in = 10'd5;
      sample_in_valid = 1'b1;
      repeat (10) begin
         tick();
         if (aud_pwm !== 1'b0 || aud_sd !== 1'b0 || sample_in_ready !== 1'b0 ||
             fifo_level !== 3'd0 || underrun !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL reset_hold: %0d bad cycles, required 0", errs); end
      sample_in_valid = 1'b0;
      enable = 1'b0;
      rst_n = 1'b1;
      tick(); tick();
      total++;
      if (sample_in_ready !== 1'b0 || aud_sd !== 1'b0) begin
         bad++; $display("FAIL off_idle: ready=%b sd=%b, required 0 0", sample_in_ready, aud_sd);
      end
   endtask

   task automatic test_basic_pwm();
      int highs;
      int sd_errs = 0;
      do_reset();
      enable = 1'b1;
      tick();
      push(10'd256);                    // E0
      tick();                           // E1: PLAY entered, pwm not yet driven
      total++;
      if (aud_pwm !== 1'b0) begin bad++; $display("FAIL basic_e1: pwm=%b, required 0", aud_pwm); end
      tick();                           // E2: first high
      total++;
      if (aud_pwm !== 1'b1) begin bad++; $display("FAIL basic_first_high: pwm=%b, required 1", aud_pwm); end
      for (int p = 0; p < 2; p++) begin
         highs = 0;
         for (int i = 0; i < 1024; i++) begin
            if (aud_pwm === 1'b1) highs++;
            if (aud_sd !== 1'b1) sd_errs++;
            tick();
         end
         total++;
         if (highs != 256) begin bad++; $display("FAIL basic_highs_p%0d: got %0d, required 256", p, highs); end
      end
      total++;
      if (sd_errs != 0) begin bad++; $display("FAIL basic_sd: %0d cycles sd!=1, required 0", sd_errs); end
   endtask

   task automatic test_extremes();
      int lows = 0;
      int errs = 0;
      do_reset();
      enable = 1'b1;
      tick();
      push(10'd0);                      // E0
      push(10'd1023);                   // E1
      tick();                           // E2
      for (int i = 0; i < 1024; i++) begin
         if (aud_pwm === 1'b0) lows++;
         tick();
      end
      total++;
      if (lows != 1024) begin bad++; $display("FAIL extreme_zero: low cycles=%0d, required 1024", lows); end
      for (int i = 0; i < 1024; i++) begin
         if (aud_pwm !== (i < 1023)) errs++;
         if (i == 1023) begin
            total++;
            if (aud_pwm !== 1'b0) begin bad++; $display("FAIL extreme_last_low: pwm=%b, required 0", aud_pwm); end
         end
         tick();
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL extreme_max: %0d wrong cycles, required 0", errs); end
   endtask

   task automatic test_backpressure();
      int accepts = 0;
      bit r;
      do_reset();
      enable = 1'b1;
      tick();
      push(10'd100);                    // E0
      tick();                           // E1: PLAY, counter 0
      sample_in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sample_in = 10'(200 + accepts);
         r = sample_in_ready;
         tick();
         if (r) accepts++;
      end                               // E9
      total++;
      if (accepts != 4) begin bad++; $display("FAIL bp_accepts: got %0d, required 4", accepts); end
      total++;
      if (sample_in_ready !== 1'b0 || fifo_level !== 3'd4) begin
         bad++; $display("FAIL bp_full: ready=%b level=%0d, required 0 4", sample_in_ready, fifo_level);
      end
      repeat (1015) tick();             // E1024: counter at 1023
      total++;
      if (sample_in_ready !== 1'b0) begin bad++; $display("FAIL bp_pre_pop: ready=%b, required 0", sample_in_ready); end
      tick();                           // E1025: boundary pop done
      total++;
      if (sample_in_ready !== 1'b1 || fifo_level !== 3'd3) begin
         bad++; $display("FAIL bp_post_pop: ready=%b level=%0d, required 1 3", sample_in_ready, fifo_level);
      end
      sample_in_valid = 1'b0;
   endtask

   task automatic test_underrun();
      int pulses = 0;
      int und_errs = 0;
      int pwm_errs = 0;
      do_reset();
      enable = 1'b1;
      tick();
      push(10'd512);                    // E0
      tick(); tick();                   // E2
      for (int i = 2; i <= 3073; i++) begin
         if (underrun === 1'b1) pulses++;
         if (underrun !== (i == 1025 || i == 2049 || i == 3073)) und_errs++;
         if (aud_pwm !== (((i - 2) % 1024) < 512)) pwm_errs++;
         if (i < 3073) tick();
      end
      total++;
      if (pulses != 3) begin bad++; $display("FAIL und_pulses: got %0d, required 3", pulses); end
      total++;
      if (und_errs != 0) begin bad++; $display("FAIL und_timing: %0d wrong cycles, required 0", und_errs); end
      total++;
      if (pwm_errs != 0) begin bad++; $display("FAIL und_duty_kept: %0d wrong cycles, required 0", pwm_errs); end
`ifdef AUD_DAC_UNDERRUN_CNT_EN
      total++;
      if (underrun_count !== 16'd3) begin bad++; $display("FAIL und_count: got %0d, required 3", underrun_count); end
`endif
   endtask

   task automatic test_mid_drop();
      do_reset();
      enable = 1'b1;
      tick();
      push(10'd600);                    // E0
      tick();                           // E1
      push(10'd700);                    // E2
      push(10'd800);                    // E3
      total++;
      if (fifo_level !== 3'd2) begin bad++; $display("FAIL drop_level_pre: got %0d, required 2", fifo_level); end
      repeat (298) tick();              // E301: counter = 300
      total++;
      if (aud_pwm !== 1'b1) begin bad++; $display("FAIL drop_pre_high: pwm=%b, required 1", aud_pwm); end
      enable = 1'b0;
      tick();                           // E302: OFF
      total++;
      if (aud_pwm !== 1'b0 || aud_sd !== 1'b0 || fifo_level !== 3'd0 || sample_in_ready !== 1'b0) begin
         bad++;
         $display("FAIL drop_off: pwm=%b sd=%b level=%0d ready=%b, required 0 0 0 0",
                  aud_pwm, aud_sd, fifo_level, sample_in_ready);
      end
      enable = 1'b1;
      tick(); tick(); tick();           // PRIME, starved
      total++;
      if (aud_sd !== 1'b0 || sample_in_ready !== 1'b1 || fifo_level !== 3'd0) begin
         bad++;
         $display("FAIL drop_prime: sd=%b ready=%b level=%0d, required 0 1 0", aud_sd, sample_in_ready, fifo_level);
      end
      push(10'd100);
      tick();
      total++;
      if (aud_sd !== 1'b1 || aud_pwm !== 1'b0) begin
         bad++; $display("FAIL drop_replay_e1: sd=%b pwm=%b, required 1 0", aud_sd, aud_pwm);
      end
      tick();
      total++;
      if (aud_pwm !== 1'b1) begin bad++; $display("FAIL drop_replay_e2: pwm=%b, required 1", aud_pwm); end
   endtask

   task automatic test_async_reset();
      do_reset();
      enable = 1'b1;
      tick();
      push(10'd1000);
      push(10'd900);
      repeat (10) tick();
      total++;
      if (aud_pwm !== 1'b1 || aud_sd !== 1'b1) begin
         bad++; $display("FAIL async_pre: pwm=%b sd=%b, required 1 1", aud_pwm, aud_sd);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (aud_pwm !== 1'b0 || aud_sd !== 1'b0 || sample_in_ready !== 1'b0 ||
          fifo_level !== 3'd0 || underrun !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: pwm=%b sd=%b ready=%b level=%0d und=%b, required all 0",
                  aud_pwm, aud_sd, sample_in_ready, fifo_level, underrun);
      end
      enable = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_pwm();
      test_extremes();
      test_backpressure();
      test_underrun();
      test_mid_drop();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
